// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the load/store path.
//   ls_state_t : memory-access FSM states
//   WORD_BYTES : bytes per data word (byte address = word address * 4)
//   word_t     : 32-bit data word
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      DONE      = 2'd2
   } ls_state_t;

   localparam int WORD_BYTES = 4;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/load_store_unit.sv
// Memory-access stage between execute and the GPR/FPR write stages.
// Takes one load or store at a time, drives the data BRAM port and waits out
// the BRAM read latency for loads.
//   clk, rstn                       : clock, asynchronous active-low reset
//   ls_valid/ls_ready               : request handshake (sampled when ready)
//   ls_store, ls_fp, ls_addr, ls_wdata : request attributes
//   gl_valid / fl_valid             : GPR / FPR load-accepted pulse
//   load_finish, rdata              : load completion pulse and held result
//   store_finish                    : store-issued pulse
//   misalign_err                    : rejected request (ls_addr[1:0] != 0)
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata : BRAM port
module load_store_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = 17,
   parameter int MEM_LATENCY = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                ls_valid,
   output logic                ls_ready,
   input  logic                ls_store,
   input  logic                ls_fp,
   input  logic [ADDR_W+1:0]   ls_addr,
   input  word_t               ls_wdata,
   output logic                gl_valid,
   output logic                fl_valid,
   output logic                load_finish,
   output word_t               rdata,
   output logic                store_finish,
   output logic                misalign_err,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output word_t               mem_wdata,
   input  word_t               mem_rdata
);

   localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

   ls_state_t          state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   word_t              rdata_q, rdata_d;
   logic               gl_valid_q, gl_valid_d;
   logic               fl_valid_q, fl_valid_d;
   logic               store_finish_q, store_finish_d;
   logic               misalign_err_q, misalign_err_d;
   logic               mem_en_q, mem_en_d;
   logic               mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   word_t              mem_wdata_q, mem_wdata_d;

   logic               aligned;
   assign aligned = (ls_addr[1:0] == 2'b00);

   // State register (and all registered outputs)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         rdata_q        <= '0;
         gl_valid_q     <= 1'b0;
         fl_valid_q     <= 1'b0;
         store_finish_q <= 1'b0;
         misalign_err_q <= 1'b0;
         mem_en_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rdata_q        <= rdata_d;
         gl_valid_q     <= gl_valid_d;
         fl_valid_q     <= fl_valid_d;
         store_finish_q <= store_finish_d;
         misalign_err_q <= misalign_err_d;
         mem_en_q       <= mem_en_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
      end
   end

   // Next-state logic, latency counter and load-data capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (ls_valid && aligned && !ls_store) begin
               state_d = READ_WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         READ_WAIT: begin
            // The first READ_WAIT cycle is the one that presents mem_en to
            // the BRAM; the latency count starts in the cycle after it, so
            // the capture lands exactly on the cycle mem_rdata is valid.
            if (!mem_en_q) begin
               if (cnt_q == 3'd0) begin
                  rdata_d = mem_rdata;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: registered pulses and BRAM port
   always_comb begin
      gl_valid_d     = 1'b0;
      fl_valid_d     = 1'b0;
      store_finish_d = 1'b0;
      misalign_err_d = 1'b0;
      mem_en_d       = 1'b0;
      mem_we_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      if (state_q == IDLE && ls_valid) begin
         if (!aligned) begin
            misalign_err_d = 1'b1;
         end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = ls_addr[ADDR_W+1:2];
            if (ls_store) begin
               mem_we_d       = 1'b1;
               mem_wdata_d    = ls_wdata;
               store_finish_d = 1'b1;
            end else begin
               // Arm pulse coincides with mem_en so the write stage is
               // already waiting when load_finish arrives.
               gl_valid_d = !ls_fp;
               fl_valid_d = ls_fp;
            end
         end
      end
   end

   assign ls_ready     = (state_q == IDLE);
   assign load_finish  = (state_q == DONE);
   assign rdata        = rdata_q;
   assign gl_valid     = gl_valid_q;
   assign fl_valid     = fl_valid_q;
   assign store_finish = store_finish_q;
   assign misalign_err = misalign_err_q;
   assign mem_en       = mem_en_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam int ADDR_W = 17;
   localparam int LAT    = 2;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              ls_valid = 1'b0;
   logic              ls_ready;
   logic              ls_store = 1'b0;
   logic              ls_fp = 1'b0;
   logic [ADDR_W+1:0] ls_addr = '0;
   logic [31:0]       ls_wdata = '0;
   logic              gl_valid, fl_valid, load_finish, store_finish, misalign_err;
   logic [31:0]       rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   int checks = 0;
   int errors = 0;
   int write_count = 0;
   int excl_violations = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rstn(rstn),
      .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_store(ls_store), .ls_fp(ls_fp),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .gl_valid(gl_valid), .fl_valid(fl_valid), .load_finish(load_finish),
      .rdata(rdata), .store_finish(store_finish), .misalign_err(misalign_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // BRAM model: read data valid LAT cycles after the cycle mem_en is high
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic [31:0] pipe [0:LAT-1];
   assign mem_rdata = pipe[LAT-1];

   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         write_count <= write_count + 1;
      end
      if (mem_en && !mem_we) pipe[0] <= mem[mem_addr];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   // Protocol monitor: pulse exclusivity and mem_we only with mem_en
   always @(negedge clk) begin
      if (rstn) begin
         if ((int'(gl_valid) + int'(fl_valid) + int'(load_finish) +
              int'(store_finish) + int'(misalign_err)) > 1)
            excl_violations <= excl_violations + 1;
         if (mem_we && !mem_en) excl_violations <= excl_violations + 1;
      end
   end

   // Full load transaction with cycle-exact checks; accept edge = cycle 0
   task automatic do_load(input logic [ADDR_W+1:0] addr, input logic fp,
                          input logic [31:0] exp, input string name);
      @(negedge clk);
      ls_valid = 1'b1; ls_store = 1'b0; ls_fp = fp; ls_addr = addr;
      @(posedge clk);
      @(negedge clk);
      ls_valid = 1'b0;
      checks++;
      if (gl_valid !== !fp || fl_valid !== fp) begin
         errors++;
         $display("FAIL %s arm: gl=%b fl=%b required gl=%b fl=%b", name, gl_valid, fl_valid, !fp, fp);
      end
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr[ADDR_W+1:2]) begin
         errors++;
         $display("FAIL %s issue: en=%b we=%b addr=%h required en=1 we=0 addr=%h",
                  name, mem_en, mem_we, mem_addr, addr[ADDR_W+1:2]);
      end
      checks++;
      if (ls_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: ls_ready=%b required 0", name, ls_ready);
      end
      for (int c = 2; c <= LAT + 3; c++) begin
         @(negedge clk);
         checks++;
         if (gl_valid !== 1'b0 || fl_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s arm_extra cycle %0d: gl=%b fl=%b required 0 0", name, c, gl_valid, fl_valid);
         end
         checks++;
         if (load_finish !== (c == LAT + 2)) begin
            errors++;
            $display("FAIL %s finish cycle %0d: load_finish=%b required %b", name, c, load_finish, c == LAT + 2);
         end
         if (c >= LAT + 2) begin
            checks++;
            if (rdata !== exp) begin
               errors++;
               $display("FAIL %s rdata cycle %0d: got %h required %h", name, c, rdata, exp);
            end
         end
      end
      checks++;
      if (ls_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_after: ls_ready=%b required 1", name, ls_ready);
      end
      $display("load  addr=%h fp=%b rdata=%h", addr, fp, rdata);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ls_ready !== 1'b1 || rdata !== 32'h0 || mem_en !== 1'b0 || mem_we !== 1'b0 ||
          mem_addr !== '0 || mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: ready=%b rdata=%h en=%b we=%b addr=%h wdata=%h required 1 0 0 0 0 0",
                  ls_ready, rdata, mem_en, mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if ({gl_valid, fl_valid, load_finish, store_finish, misalign_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_pulses: got %b required 00000",
                  {gl_valid, fl_valid, load_finish, store_finish, misalign_err});
      end
      rstn = 1'b1;
      $display("reset released");
   endtask

   task automatic test_gpr_load();
      mem[4] = 32'hDEADBEEF;
      do_load(19'h00010, 1'b0, 32'hDEADBEEF, "gpr_load");
   endtask

   task automatic test_fpr_load();
      mem[17'h7FFF] = 32'hCAFEF00D;
      do_load(19'h1FFFC, 1'b1, 32'hCAFEF00D, "fpr_load");
   endtask

   task automatic test_back_to_back_stores();
      int w0;
      w0 = write_count;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         ls_valid = 1'b1; ls_store = 1'b1; ls_fp = 1'b0;
         ls_addr = 19'(i * 4); ls_wdata = 32'(i + 1);
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (store_finish !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
             mem_addr !== 17'(i) || mem_wdata !== 32'(i + 1) || ls_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_%0d: sf=%b en=%b we=%b addr=%h wdata=%h ready=%b required 1 1 1 %h %h 1",
                     i, store_finish, mem_en, mem_we, mem_addr, mem_wdata, ls_ready, 17'(i), 32'(i + 1));
         end
         $display("store addr=%h wdata=%h", mem_addr, mem_wdata);
      end
      ls_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem[0] !== 32'd1 || mem[1] !== 32'd2 || mem[2] !== 32'd3 || write_count - w0 != 3) begin
         errors++;
         $display("FAIL store_contents: words %h %h %h writes %0d required 1 2 3 writes 3",
                  mem[0], mem[1], mem[2], write_count - w0);
      end
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      ls_valid = 1'b1; ls_store = 1'b0; ls_fp = 1'b0; ls_addr = 19'h00006;
      @(posedge clk);
      @(negedge clk);
      ls_valid = 1'b0;
      checks++;
      if (misalign_err !== 1'b1 || mem_en !== 1'b0 || gl_valid !== 1'b0 || ls_ready !== 1'b1) begin
         errors++;
         $display("FAIL misalign: err=%b en=%b gl=%b ready=%b required 1 0 0 1",
                  misalign_err, mem_en, gl_valid, ls_ready);
      end
      for (int c = 0; c < LAT + 3; c++) begin
         @(negedge clk);
         checks++;
         if (load_finish !== 1'b0 || misalign_err !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after cycle %0d: finish=%b err=%b en=%b required 0 0 0",
                     c, load_finish, misalign_err, mem_en);
         end
      end
      $display("misaligned addr=%h rejected", 19'h00006);
   endtask

   task automatic test_hold_during_read();
      int w0;
      int accept_cycle;
      w0 = write_count;
      accept_cycle = -1;
      @(negedge clk);
      ls_valid = 1'b1; ls_store = 1'b0; ls_fp = 1'b0; ls_addr = 19'h00010;
      @(posedge clk);
      @(negedge clk);
      // Cycle 1: swap to a store request and hold it while busy
      ls_store = 1'b1; ls_addr = 19'h00020; ls_wdata = 32'h00000055;
      for (int c = 1; c <= 10 && accept_cycle < 0; c++) begin
         if (c > 1) @(negedge clk);
         checks++;
         if (store_finish !== 1'b0) begin
            errors++;
            $display("FAIL hold_premature cycle %0d: store_finish=1 required 0", c);
         end
         if (ls_ready === 1'b1) accept_cycle = c;
      end
      checks++;
      if (accept_cycle != LAT + 3) begin
         errors++;
         $display("FAIL hold_ready_cycle: got %0d required %0d", accept_cycle, LAT + 3);
      end
      @(negedge clk);
      ls_valid = 1'b0;
      checks++;
      if (store_finish !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'h8 || mem_wdata !== 32'h55) begin
         errors++;
         $display("FAIL hold_store: sf=%b we=%b addr=%h wdata=%h required 1 1 8 55",
                  store_finish, mem_we, mem_addr, mem_wdata);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (write_count - w0 != 1 || mem[8] !== 32'h55) begin
         errors++;
         $display("FAIL hold_writes: writes %0d word8 %h required 1 55", write_count - w0, mem[8]);
      end
      $display("held store addr=%h accepted at cycle %0d", 19'h00020, accept_cycle);
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      ls_valid = 1'b1; ls_store = 1'b0; ls_fp = 1'b0; ls_addr = 19'h00010;
      @(posedge clk);
      @(negedge clk);
      ls_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if (ls_ready !== 1'b1 || rdata !== 32'h0 || mem_en !== 1'b0 || mem_addr !== '0 ||
          mem_wdata !== 32'h0 || load_finish !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: ready=%b rdata=%h en=%b addr=%h wdata=%h finish=%b required 1 0 0 0 0 0",
                  ls_ready, rdata, mem_en, mem_addr, mem_wdata, load_finish);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < LAT + 4; c++) begin
         @(negedge clk);
         checks++;
         if (load_finish !== 1'b0 || ls_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after cycle %0d: finish=%b ready=%b required 0 1", c, load_finish, ls_ready);
         end
      end
      $display("reset during READ_WAIT aborted load");
      do_load(19'h1FFFC, 1'b1, 32'hCAFEF00D, "post_reset_load");
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) pipe[i] = 32'h0;
      test_reset();
      test_gpr_load();
      test_fpr_load();
      test_back_to_back_stores();
      test_misaligned();
      test_hold_during_read();
      test_reset_mid_read();
      checks++;
      if (excl_violations != 0) begin
         errors++;
         $display("FAIL exclusivity: violations %0d required 0", excl_violations);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
